// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and the framebuffer address helper.
package vga_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE_SH = 2;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYN   = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYN + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYN   = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYN + V_BP;

  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int CNT_W    = 10;

  typedef logic [2:0] colour_t;

  // Row-major address for a 160-wide buffer: y*160 = y*128 + y*32, no multiplier needed.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] fb_y, input logic [7:0] fb_x);
    logic [ADDR_W-1:0] y_ext;
    y_ext   = {8'd0, fb_y};
    fb_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, fb_x};
  endfunction

endpackage

// File: rtl/framebuffer_ram.sv
// Simple dual-port 19200x3 framebuffer; registered read returns the old word when the
// same address is written in the same clock.
module framebuffer_ram
  import vga_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  colour_t           wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output colour_t           rd_q
);

  colour_t mem_r [0:FB_DEPTH-1];
  colour_t rd_q_r;

  // write port and registered read port, no reset so the array maps onto block RAM
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_q_r <= mem_r[rd_addr];
  end

  assign rd_q = rd_q_r;

endmodule

// File: rtl/vga_frame_scanout.sv
// Pixel-plot framebuffer consumer: stores 160x120 writes and scans them out as
// 640x480@60 VGA with 4x replication, plus a once-per-frame sync pulse.
module vga_frame_scanout #(
  parameter int H_VIS = vga_pkg::H_VIS,
  parameter int H_FP  = vga_pkg::H_FP,
  parameter int H_SYN = vga_pkg::H_SYN,
  parameter int H_BP  = vga_pkg::H_BP,
  parameter int V_VIS = vga_pkg::V_VIS,
  parameter int V_FP  = vga_pkg::V_FP,
  parameter int V_SYN = vga_pkg::V_SYN,
  parameter int V_BP  = vga_pkg::V_BP
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       frame_sync,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_VIS + H_FP + H_SYN + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_VIS + V_FP + V_SYN + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG_C  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C  = CNT_W'(H_VIS + H_FP + H_SYN);
  localparam logic [CNT_W-1:0] VS_BEG_C  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C  = CNT_W'(V_VIS + V_FP + V_SYN);
  localparam logic [7:0]       FB_W_C    = 8'(FB_W);
  localparam logic [6:0]       FB_H_C    = 7'(FB_H);

  logic              pix_en_r;
  logic              vga_clk_r;
  logic [CNT_W-1:0]  hcnt_r;
  logic [CNT_W-1:0]  vcnt_r;
  logic [CNT_W-1:0]  hcnt_nxt_s;
  logic [CNT_W-1:0]  vcnt_nxt_s;
  logic              visible_s;
  logic              hs_s;
  logic              vs_s;
  logic              fsync_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              we_s;
  colour_t           rd_q_s;
  logic [9:0]        red_s;
  logic [9:0]        grn_s;
  logic [9:0]        blu_s;
  logic              hs_r;
  logic              vs_r;
  logic              blank_n_r;
  logic              fsync_r;
  logic [9:0]        red_r;
  logic [9:0]        grn_r;
  logic [9:0]        blu_r;

  // pixel enable toggles every clock; VGA_CLK rises mid pixel period, while pins are stable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_r  <= 1'b0;
      vga_clk_r <= 1'b0;
    end else begin
      pix_en_r  <= ~pix_en_r;
      vga_clk_r <= ~pix_en_r;
    end
  end

  // next raster position
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    if (hcnt_r == H_LAST_C) begin
      hcnt_nxt_s = CNT_ZERO;
      if (vcnt_r == V_LAST_C) begin
        vcnt_nxt_s = CNT_ZERO;
      end else begin
        vcnt_nxt_s = vcnt_r + CNT_ONE;
      end
    end else begin
      hcnt_nxt_s = hcnt_r + CNT_ONE;
    end
  end

  // raster counters advance once per pixel period
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r <= CNT_ZERO;
      vcnt_r <= CNT_ZERO;
    end else if (pix_en_r) begin
      hcnt_r <= hcnt_nxt_s;
      vcnt_r <= vcnt_nxt_s;
    end
  end

  // raster decode, read address and pixel colour expansion
  always_comb begin
    visible_s = (hcnt_r < H_VIS_C) && (vcnt_r < V_VIS_C);
    hs_s      = !((hcnt_r >= HS_BEG_C) && (hcnt_r < HS_END_C));
    vs_s      = !((vcnt_r >= VS_BEG_C) && (vcnt_r < VS_END_C));
    fsync_s   = pix_en_r && (hcnt_nxt_s == CNT_ZERO) && (vcnt_nxt_s == V_VIS_C);
    if (visible_s) begin
      rd_addr_s = fb_addr(vcnt_r[SCALE_SH +: 7], hcnt_r[SCALE_SH +: 8]);
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
    red_s = (visible_s && rd_q_s[2]) ? 10'h3FF : 10'h000;
    grn_s = (visible_s && rd_q_s[1]) ? 10'h3FF : 10'h000;
    blu_s = (visible_s && rd_q_s[0]) ? 10'h3FF : 10'h000;
  end

  // write qualification: out-of-range coordinates are dropped
  always_comb begin
    we_s      = plot && (x < FB_W_C) && (y < FB_H_C);
    wr_addr_s = fb_addr(y, x);
  end

  framebuffer_ram u_fb (
    .clock   (clock),
    .we      (we_s),
    .wr_addr (wr_addr_s),
    .wr_data (colour),
    .rd_addr (rd_addr_s),
    .rd_q    (rd_q_s)
  );

  // output pipeline: data, sync and blank share one stage so they stay aligned
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_n_r <= 1'b0;
      fsync_r   <= 1'b0;
      red_r     <= 10'h000;
      grn_r     <= 10'h000;
      blu_r     <= 10'h000;
    end else begin
      fsync_r <= fsync_s;
      if (pix_en_r) begin
        hs_r      <= hs_s;
        vs_r      <= vs_s;
        blank_n_r <= visible_s;
        red_r     <= red_s;
        grn_r     <= grn_s;
        blu_r     <= blu_s;
      end
    end
  end

  assign frame_sync  = fsync_r;
  assign VGA_CLK     = vga_clk_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK_N = blank_n_r;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = red_r;
  assign VGA_G       = grn_r;
  assign VGA_B       = blu_r;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Self-checking bench for vga_frame_scanout with a shortened vertical frame and
// randomized plot traffic checked against a pixel-timing reference model.
module tb_vga_frame_scanout;
  import vga_pkg::*;

  localparam int TV_VIS    = 16;
  localparam int TV_FP     = 1;
  localparam int TV_SYN    = 2;
  localparam int TV_BP     = 1;
  localparam int HT        = H_VIS + H_FP + H_SYN + H_BP;
  localparam int VT        = TV_VIS + TV_FP + TV_SYN + TV_BP;
  localparam int FRAME_PIX = HT * VT;
  localparam int RUN1      = 4 * FRAME_PIX + 2 * (HT + 300);
  localparam int RUN2      = 1400;
  localparam int COLL_EDGE = 2 * (3 * HT + 3) + 1;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       frame_sync, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  vga_frame_scanout #(
    .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYN(TV_SYN), .V_BP(TV_BP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .x(x), .y(y), .colour(colour), .plot(plot),
    .frame_sync(frame_sync), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int k, phase;
  logic [2:0] snap, disp;
  logic [2:0] fb_model [0:FB_W*FB_H-1];
  int hs_low_l0, vs_low_f0, rect_hits, neigh_lit, white_px, first_hs, fs_seen;
  int fs_cnt [0:2];
  int g00 [0:1];
  int fs_edge [0:1];

  localparam logic [35:0] RST_PINS = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'd0};

  task automatic check_val(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s at edge %0d: observed %0h expected %0h", tag, k, obs, exp_v);
    end
  endtask

  function automatic logic [35:0] pins_now();
    return {frame_sync, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B};
  endfunction

  // One clock: update the reference model for this edge, then compare all pins.
  task automatic step();
    int n, h, v, f;
    logic vis, in_rect;
    logic [35:0] exp_v;
    logic [29:0] rgb;
    @(posedge clock);
    k++;
    if (k % 2 == 1) begin
      n = (k - 1) / 2;
      h = n % HT;
      v = (n / HT) % VT;
      snap = (h < H_VIS && v < TV_VIS) ? fb_model[(v / 4) * FB_W + h / 4] : 3'b000;
    end else begin
      disp = snap;
    end
    if (plot && x < FB_W && y < FB_H) fb_model[y * FB_W + x] = colour;
    #1;
    if (k == 1) begin
      exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 30'd0};
    end else begin
      n   = (k - 2) / 2;
      h   = n % HT;
      v   = (n / HT) % VT;
      f   = n / FRAME_PIX;
      vis = (h < H_VIS) && (v < TV_VIS);
      exp_v = {((k % 2 == 0) && ((k / 2) % FRAME_PIX == TV_VIS * HT)),
               (k % 2 == 1),
               !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYN),
               !(v >= TV_VIS + TV_FP && v < TV_VIS + TV_FP + TV_SYN),
               vis, 1'b0,
               {10{vis & disp[2]}}, {10{vis & disp[1]}}, {10{vis & disp[0]}}};
      rgb = {VGA_R, VGA_G, VGA_B};
      in_rect = (v >= 12 && v <= 15 && h >= 20 && h <= 23);
      if (phase == 1) begin
        if (f == 0 && v == 0 && VGA_HS == 1'b0) hs_low_l0++;
        if (f == 0 && VGA_VS == 1'b0) vs_low_f0++;
        if (frame_sync == 1'b1 && f < 3) begin
          fs_cnt[f]++;
          if (fs_seen < 2) fs_edge[fs_seen] = k;
          fs_seen++;
        end
        if (f == 0 && in_rect && rgb == {10'h3FF, 10'h000, 10'h3FF}) rect_hits++;
        if (f == 0 && !in_rect && v >= 8 && v <= 15 && h >= 16 && h <= 27 && rgb != 30'd0) neigh_lit++;
        if (rgb == {30{1'b1}}) white_px++;
        if (f < 2 && h < 4 && v < 4 && VGA_G == 10'h3FF) g00[f]++;
      end else if (first_hs < 0 && VGA_HS == 1'b0) begin
        first_hs = k;
      end
    end
    check_val("pins", pins_now(), exp_v);
  endtask

  // Inputs for the coming edge: a few directed plots, otherwise random traffic.
  task automatic set_inputs(input int next_edge);
    plot = 1'b0;
    case (next_edge)
      3:         begin x = 8'd5;   y = 7'd3;   colour = 3'b101; plot = 1'b1; end
      5:         begin x = 8'd160; y = 7'd0;   colour = 3'b111; plot = 1'b1; end
      7:         begin x = 8'd0;   y = 7'd120; colour = 3'b111; plot = 1'b1; end
      COLL_EDGE: begin x = 8'd0;   y = 7'd0;   colour = 3'b010; plot = 1'b1; end
      default: begin
        if (next_edge >= 9) begin
          plot   = ($urandom_range(0, 3) == 0);
          x      = 8'($urandom_range(40, 255));
          y      = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(1, 3));
          colour = 3'($urandom_range(0, 6));
        end
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < FB_W * FB_H; i++) fb_model[i] = 3'b000;
    hs_low_l0 = 0; vs_low_f0 = 0; rect_hits = 0; neigh_lit = 0; white_px = 0;
    first_hs = -1; fs_seen = 0;
    fs_cnt[0] = 0; fs_cnt[1] = 0; fs_cnt[2] = 0; g00[0] = 0; g00[1] = 0;
    fs_edge[0] = 0; fs_edge[1] = 0;
    snap = 3'b000; disp = 3'b000; k = 0; phase = 1;
    plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'b000;
    reset_n = 1'b0;

    repeat (10) @(posedge clock);
    #1;
    check_val("reset_pins", pins_now(), RST_PINS);

    @(negedge clock);
    reset_n = 1'b1;
    x = 8'd0; y = 7'd0; colour = 3'b000; plot = 1'b0;
    for (int e = 1; e <= RUN1; e++) begin
      step();
      set_inputs(e + 1);
    end

    // mid-line reset in the third frame (line 1, hcnt 300)
    plot = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_reset_pins", pins_now(), RST_PINS);
    repeat (4) @(posedge clock);
    #1;
    check_val("held_reset_pins", pins_now(), RST_PINS);
    @(negedge clock);
    reset_n = 1'b1;
    k = 0; snap = 3'b000; disp = 3'b000; phase = 2;
    for (int e = 1; e <= RUN2; e++) begin
      step();
      set_inputs(e + 10);
    end

    check_val("hs_low_clocks_per_line", 36'(hs_low_l0), 36'd192);
    check_val("vs_low_clocks_per_frame", 36'(vs_low_f0), 36'd3200);
    check_val("frame_sync_count_f0", 36'(fs_cnt[0]), 36'd1);
    check_val("frame_sync_count_f1", 36'(fs_cnt[1]), 36'd1);
    check_val("frame_sync_period", 36'(fs_edge[1] - fs_edge[0]), 36'(2 * FRAME_PIX));
    check_val("plot_5_3_magenta_clocks", 36'(rect_hits), 36'd32);
    check_val("plot_5_3_neighbours_lit", 36'(neigh_lit), 36'd0);
    check_val("out_of_range_white_seen", 36'(white_px), 36'd0);
    check_val("collision_same_frame_green", 36'(g00[0]), 36'd0);
    check_val("collision_next_frame_green", 36'(g00[1]), 36'd32);
    check_val("first_hs_after_reset_in_range", {35'd0, (first_hs >= 1313 && first_hs <= 1314)}, 36'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
